// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin select generator for a 4:1 mux: registered S/gnt held until ack.
// Optional grant hold timeout is enabled by defining MUX_SEL_TIMEOUT_EN.
module mux_sel_rr_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [1:0] S,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic       expire;

  if (2 ** CNT_W <= HOLD_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow for HOLD_CYCLES");
  end

  // Offsets are scanned from farthest to nearest so the closest requester to ptr wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign winner = pick(req, ptr);

`ifdef MUX_SEL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && !ack && expire;
      if (state == IDLE)
        cnt <= '0;
      else if (cnt != CNT_W'(HOLD_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      S     <= 2'd0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
      ptr   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (req != 4'b0000)) begin
            state <= GRANT;
            S     <= winner;
            gnt   <= 4'b0001 << winner;
            valid <= 1'b1;
          end
        end
        default: begin
          // A dropped grant (acked or expired) hands priority to the next channel.
          if (ack || expire) begin
            state <= IDLE;
            valid <= 1'b0;
            gnt   <= 4'b0000;
            ptr   <= S + 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Randomized and directed bench for mux_sel_rr_arbiter against a behavioural model.
// Timeout scenarios are exercised when MUX_SEL_TIMEOUT_EN is defined.
module tb_mux_sel_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;
  logic [1:0] S;
  logic [3:0] gnt;
  logic       valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who holds the mux, whose turn is next, how long held.
  int m_busy = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_age  = 0;
  int m_tmo  = 0;

  mux_sel_rr_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .S(S), .gnt(gnt), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout-of-sim, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_ptr = 0; m_age = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    int tmo_next;
    tmo_next = 0;
    if (m_busy == 0) begin
      if (en && req != 4'b0000) begin
        for (int off = 0; off < 4; off++) begin
          if (m_busy == 0 && req[(m_ptr + off) % 4]) begin
            m_busy = 1;
            m_idx  = (m_ptr + off) % 4;
            m_age  = 0;
          end
        end
      end
    end else if (ack) begin
      m_busy = 0;
      m_ptr  = (m_idx + 1) % 4;
    end else begin
`ifdef MUX_SEL_TIMEOUT_EN
      if (m_age == HOLD - 1) begin
        m_busy   = 0;
        m_ptr    = (m_idx + 1) % 4;
        tmo_next = 1;
      end else if (m_age < HOLD) begin
        m_age++;
      end
`else
      m_age++;
`endif
    end
    m_tmo = tmo_next;
  endtask

  task automatic compare_all();
    check_eq("valid", int'(valid), m_busy);
    check_eq("gnt", int'(gnt), (m_busy != 0) ? (1 << m_idx) : 0);
    if (m_busy != 0) check_eq("S", int'(S), m_idx);
    check_eq("timeout", int'(timeout), m_tmo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    compare_all();
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_gnt", int'(gnt), 0);
    check_eq("rst_S", int'(S), 0);
    check_eq("rst_timeout", int'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq[5];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int n;
    int run;
    int seen;
    int sticky_n;

    repeat (2) @(negedge clk);
    model_reset();
    check_eq("init_valid", int'(valid), 0);
    check_eq("init_gnt", int'(gnt), 0);
    check_eq("init_S", int'(S), 0);
    rst = 1'b0;

    // Reset in the middle of a grant on channel 2
    en = 1'b1; req = 4'b0100;
    tick();
    check_eq("t1_grant_S", int'(S), 2);
    do_reset();
    tick();
    check_eq("t1_regrant_S", int'(S), 2);
    check_eq("t1_regrant_gnt", int'(gnt), 4);

    // Round robin with all channels requesting
    do_reset();
    req = 4'b1111; ack = 1'b0; n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick();
      if (valid === 1'b1 && ack == 1'b0) begin
        seq[n] = int'(S);
        n++;
        ack = 1'b1;
      end else begin
        ack = 1'b0;
      end
    end
    ack = 1'b0;
    check_eq("t2_grants", n, 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t2_seq%0d", i), seq[i], exp_seq[i]);

    // Wrap and skip from ptr=3
    do_reset();
    req = 4'b0100;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    req = 4'b0110;
    tick();
    check_eq("t3_S", int'(S), 1);
    check_eq("t3_gnt", int'(gnt), 2);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    check_eq("t3_next_S", int'(S), 2);
    ack = 1'b1; tick(); ack = 1'b0;

    // Sticky grant while request and enable drop
    do_reset();
    req = 4'b0001; en = 1'b1;
    tick();
`ifdef MUX_SEL_TIMEOUT_EN
    sticky_n = 2;
`else
    sticky_n = 5;
`endif
    req = 4'b0000; en = 1'b0;
    for (int i = 0; i < sticky_n; i++) tick();
    check_eq("t4_valid_held", int'(valid), 1);
    check_eq("t4_S_held", int'(S), 0);
    ack = 1'b1; tick(); ack = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    check_eq("t4_no_grant", int'(valid), 0);
    en = 1'b1;

`ifdef MUX_SEL_TIMEOUT_EN
    // Grant expires without ack and is re-granted
    do_reset();
    req = 4'b0001; run = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (seen == 0) begin
        if (valid === 1'b1) run++;
        else if (timeout === 1'b1) begin
          check_eq("t5_hold_len", run, HOLD);
          seen = 1;
        end
      end
    end
    check_eq("t5_timeout_seen", seen, 1);

    // Ack on the expiry edge
    do_reset();
    req = 4'b0011;
    tick();
    for (int i = 0; i < HOLD - 1; i++) tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("t6_no_timeout", int'(timeout), 0);
    tick();
    check_eq("t6_next_S", int'(S), 1);
    ack = 1'b1; tick(); ack = 1'b0;
`else
    // Without the timeout feature a grant is held indefinitely
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check_eq("t6_valid_held", int'(valid), 1);
    check_eq("t6_timeout_zero", int'(timeout), 0);
    ack = 1'b1; tick(); ack = 1'b0;
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) == 0);
      tick();
    end
    ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
